// File: rtl/qbus_pkg.sv
// Shared widths and state encoding for the QBUS target engine.
package qbus_pkg;

    localparam int IOPAGE_ABITS = 13;
    localparam int DATA_BITS    = 16;
    localparam int CNT_BITS     = 8;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_DECODE    = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_RD_SETUP  = 3'd4,
        ST_RD_RPLY   = 3'd5,
        ST_WR_RPLY   = 3'd6,
        ST_NOREPLY   = 3'd7
    } state_e;

endpackage

// File: rtl/qbus_if.sv
// External QBUS pins (post-transceiver) plus the internal register-block bus.
interface qbus_if;

    logic [qbus_pkg::DATA_BITS-1:0]    qDAL_in;
    logic                              qBS7;
    logic                              qSYNC;
    logic                              qDIN;
    logic                              qDOUT;
    logic                              qWTBT;
    logic [qbus_pkg::DATA_BITS-1:0]    qDAL_out;
    logic                              qDAL_oe;
    logic                              qRPLY;
    logic [qbus_pkg::IOPAGE_ABITS-1:0] iADDR;
    logic                              iBS7;
    logic                              iWRITE;
    logic [qbus_pkg::DATA_BITS-1:0]    iWDATA;
    logic                              iBYTE;
    logic                              iREAD_MATCH;
    logic                              iWRITE_MATCH;
    logic [qbus_pkg::DATA_BITS-1:0]    iRDATA;

    modport slave (
        input  qDAL_in, qBS7, qSYNC, qDIN, qDOUT, qWTBT,
        input  iREAD_MATCH, iWRITE_MATCH, iRDATA,
        output qDAL_out, qDAL_oe, qRPLY,
        output iADDR, iBS7, iWRITE, iWDATA, iBYTE
    );

    modport master (
        output qDAL_in, qBS7, qSYNC, qDIN, qDOUT, qWTBT,
        output iREAD_MATCH, iWRITE_MATCH, iRDATA,
        input  qDAL_out, qDAL_oe, qRPLY,
        input  iADDR, iBS7, iWRITE, iWDATA, iBYTE
    );

endinterface

// File: rtl/qbus_sync.sv
// N-flop strobe synchronizer; edges are taken from the last two stages.
module qbus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sr_q;

    // Shift the asynchronous strobe through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[STAGES-2:0], d_i};
        end
    end

    assign level_o = sr_q[STAGES-1];
    assign rise_o  = sr_q[STAGES-2] & ~sr_q[STAGES-1];
    assign fall_o  = ~sr_q[STAGES-2] & sr_q[STAGES-1];

endmodule

// File: rtl/qbus_target.sv
// QBUS slave cycle engine: decodes DATI/DATO(B)/DATIO and drives the internal I/O bus.
module qbus_target
    import qbus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_SETUP  = 2
) (
    input  logic  clk,
    input  logic  reset_n,
    qbus_if.slave bus
);

    logic sync_lvl_s, sync_rise_s, sync_fall_s;
    logic din_lvl_s,  din_rise_s,  din_fall_s;
    logic dout_lvl_s, dout_rise_s, dout_fall_s;
    logic unused_edges_s;

    logic [DATA_BITS-1:0]    dal_q;
    logic                    bs7_q;
    logic                    wtbt_q;
    state_e                  state_q;
    logic [CNT_BITS-1:0]     cnt_q;
    logic [DATA_BITS-1:0]    dal_out_q;
    logic                    dal_oe_q;
    logic                    rply_q;
    logic [IOPAGE_ABITS-1:0] addr_q;
    logic                    ibs7_q;
    logic                    write_q;
    logic [DATA_BITS-1:0]    wdata_q;
    logic                    byte_q;

    qbus_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
        .clk(clk), .reset_n(reset_n), .d_i(bus.qSYNC),
        .level_o(sync_lvl_s), .rise_o(sync_rise_s), .fall_o(sync_fall_s)
    );
    qbus_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk(clk), .reset_n(reset_n), .d_i(bus.qDIN),
        .level_o(din_lvl_s), .rise_o(din_rise_s), .fall_o(din_fall_s)
    );
    qbus_sync #(.STAGES(SYNC_STAGES)) u_sync_dout (
        .clk(clk), .reset_n(reset_n), .d_i(bus.qDOUT),
        .level_o(dout_lvl_s), .rise_o(dout_rise_s), .fall_o(dout_fall_s)
    );

    assign unused_edges_s = &{1'b0, sync_fall_s, din_rise_s, din_fall_s, dout_rise_s, dout_fall_s};

    // Address/data lines are sampled every cycle; the synchronized strobes say when they are stable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dal_q  <= '0;
            bs7_q  <= 1'b0;
            wtbt_q <= 1'b0;
        end else begin
            dal_q  <= bus.qDAL_in;
            bs7_q  <= bus.qBS7;
            wtbt_q <= bus.qWTBT;
        end
    end

    // Bus cycle FSM; SYNC negation in any engaged state returns to IDLE with address held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_WAIT_IDLE;
            cnt_q     <= '0;
            dal_out_q <= '0;
            dal_oe_q  <= 1'b0;
            rply_q    <= 1'b0;
            addr_q    <= '0;
            ibs7_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            byte_q    <= 1'b0;
        end else begin
            write_q <= 1'b0;
            if ((state_q != ST_WAIT_IDLE) && (state_q != ST_IDLE) && !sync_lvl_s) begin
                rply_q   <= 1'b0;
                dal_oe_q <= 1'b0;
                ibs7_q   <= 1'b0;
                state_q  <= ST_IDLE;
            end else begin
                case (state_q)
                    // Let the cleared synchronizer refill before trusting SYNC=0.
                    ST_WAIT_IDLE: begin
                        if (cnt_q < CNT_BITS'(SYNC_STAGES)) begin
                            cnt_q <= cnt_q + CNT_BITS'(1);
                        end else if (!sync_lvl_s) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (sync_rise_s) begin
                            addr_q  <= dal_q[IOPAGE_ABITS-1:0];
                            ibs7_q  <= bs7_q;
                            state_q <= ST_DECODE;
                        end
                    end
                    ST_DECODE: begin
                        state_q <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (din_lvl_s) begin
                            if (bus.iREAD_MATCH) begin
                                dal_out_q <= bus.iRDATA;
                                dal_oe_q  <= 1'b1;
                                cnt_q     <= '0;
                                state_q   <= ST_RD_SETUP;
                            end else begin
                                state_q <= ST_NOREPLY;
                            end
                        end else if (dout_lvl_s) begin
                            if (bus.iWRITE_MATCH) begin
                                write_q <= 1'b1;
                                wdata_q <= dal_q;
                                byte_q  <= wtbt_q;
                                rply_q  <= 1'b1;
                                state_q <= ST_WR_RPLY;
                            end else begin
                                state_q <= ST_NOREPLY;
                            end
                        end
                    end
                    ST_RD_SETUP: begin
                        if (cnt_q >= CNT_BITS'(DATA_SETUP - 1)) begin
                            rply_q  <= 1'b1;
                            state_q <= ST_RD_RPLY;
                        end else begin
                            cnt_q <= cnt_q + CNT_BITS'(1);
                        end
                    end
                    ST_RD_RPLY: begin
                        if (!din_lvl_s) begin
                            rply_q   <= 1'b0;
                            dal_oe_q <= 1'b0;
                            state_q  <= ST_ACTIVE;
                        end
                    end
                    ST_WR_RPLY: begin
                        if (!dout_lvl_s) begin
                            rply_q  <= 1'b0;
                            state_q <= ST_ACTIVE;
                        end
                    end
                    ST_NOREPLY: begin
                        state_q <= ST_NOREPLY;
                    end
                    default: begin
                        state_q <= ST_WAIT_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.qDAL_out = dal_out_q;
    assign bus.qDAL_oe  = dal_oe_q;
    assign bus.qRPLY    = rply_q;
    assign bus.iADDR    = addr_q;
    assign bus.iBS7     = ibs7_q;
    assign bus.iWRITE   = write_q;
    assign bus.iWDATA   = wdata_q;
    assign bus.iBYTE    = byte_q;

endmodule

// File: tb/tb_qbus_target.sv
// Bench for qbus_target: directed bus scenarios plus random cycles against a register-file model.
module tb_qbus_target;

    localparam int          S      = 2;
    localparam int          DS     = 2;
    localparam logic [12:0] BASE   = 13'o17770;
    localparam logic [15:0] PRESET = 16'o123456;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    qbus_if bus();

    qbus_target #(.SYNC_STAGES(S), .DATA_SETUP(DS)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Two-register responder block at BASE (BS7 must be set).
    logic [15:0] rsp [2] = '{PRESET, PRESET};
    logic        hit;
    always_comb begin
        hit              = bus.iBS7 && (bus.iADDR[12:2] == BASE[12:2]);
        bus.iREAD_MATCH  = hit;
        bus.iWRITE_MATCH = hit;
        bus.iRDATA       = hit ? rsp[bus.iADDR[1]] : 16'h0000;
    end
    always @(posedge clk) begin
        if (bus.iWRITE && hit) begin
            if (!bus.iBYTE)        rsp[bus.iADDR[1]]       <= bus.iWDATA;
            else if (bus.iADDR[0]) rsp[bus.iADDR[1]][15:8] <= bus.iWDATA[15:8];
            else                   rsp[bus.iADDR[1]][7:0]  <= bus.iWDATA[7:0];
        end
    end

    // Reference contents of the two registers.
    logic [15:0] mdl [2] = '{PRESET, PRESET};

    // Event recorder sampled shortly after each rising edge.
    int          cyc = 0, oe_rises = 0, oe_rise_cyc = 0, setup_seen = -1;
    int          rply_cyc = 0, oe_cyc = 0, wr_pulses = 0, wr_doubles = 0;
    logic [15:0] oe_data_seen = 16'h0000, wr_data_seen = 16'h0000;
    logic [12:0] wr_addr_seen = 13'h0000;
    logic        wr_byte_seen = 1'b0, prev_oe = 1'b0, prev_rply = 1'b0, prev_wr = 1'b0;
    always begin
        @(posedge clk);
        #2;
        cyc       <= cyc + 1;
        prev_oe   <= bus.qDAL_oe;
        prev_rply <= bus.qRPLY;
        prev_wr   <= bus.iWRITE;
        if (bus.qDAL_oe && !prev_oe) begin
            oe_rises     <= oe_rises + 1;
            oe_rise_cyc  <= cyc;
            oe_data_seen <= bus.qDAL_out;
        end
        if (bus.qRPLY && !prev_rply && bus.qDAL_oe) setup_seen <= cyc - oe_rise_cyc;
        if (bus.qRPLY)   rply_cyc <= rply_cyc + 1;
        if (bus.qDAL_oe) oe_cyc   <= oe_cyc + 1;
        if (bus.iWRITE) begin
            wr_pulses    <= wr_pulses + 1;
            wr_data_seen <= bus.iWDATA;
            wr_byte_seen <= bus.iBYTE;
            wr_addr_seen <= bus.iADDR;
            if (prev_wr) wr_doubles <= wr_doubles + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rply(input logic lvl, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.qRPLY === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic sync_on(input logic [12:0] a, input logic b7);
        @(negedge clk);
        bus.qDAL_in = {3'b000, a};
        bus.qBS7    = b7;
        @(negedge clk);
        bus.qSYNC = 1'b1;
        repeat (S + 3) @(negedge clk);
        bus.qDAL_in = 16'($urandom);
        bus.qBS7    = 1'($urandom);
        chk("iaddr_latch", {b7, a}, {bus.iBS7, bus.iADDR});
    endtask

    task automatic sync_off();
        bus.qSYNC = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk("sync_end_idle", {bus.qRPLY, bus.qDAL_oe, bus.iBS7}, 3'b000);
    endtask

    task automatic do_read(input string tag, input logic matched, input logic [15:0] exp);
        int   r0, o0, e0;
        logic ok;
        r0 = rply_cyc; o0 = oe_cyc; e0 = oe_rises;
        @(negedge clk);
        bus.qDIN = 1'b1;
        if (matched) begin
            wait_rply(1'b1, S + DS + 2, ok);
            chk({tag, "_rply"}, ok, 1'b1);
            chk({tag, "_oe_rise"}, oe_rises - e0, 1);
            chk({tag, "_data"}, oe_data_seen, exp);
            chk({tag, "_setup"}, setup_seen, DS);
            bus.qDIN = 1'b0;
            wait_rply(1'b0, S + 1, ok);
            chk({tag, "_drop"}, {ok, bus.qDAL_oe}, 2'b10);
        end else begin
            repeat (12) @(negedge clk);
            chk({tag, "_norply"}, rply_cyc - r0, 0);
            chk({tag, "_nooe"}, oe_cyc - o0, 0);
            bus.qDIN = 1'b0;
            repeat (S + 2) @(negedge clk);
        end
    endtask

    task automatic do_write(input string tag, input logic matched, input logic [15:0] d,
                            input logic bw, input logic [12:0] a);
        int          w0, r0, o0, dd0;
        logic        ok;
        logic [15:0] mask;
        w0 = wr_pulses; r0 = rply_cyc; o0 = oe_cyc; dd0 = wr_doubles;
        @(negedge clk);
        bus.qDAL_in = d;
        bus.qWTBT   = bw;
        @(negedge clk);
        bus.qDOUT = 1'b1;
        if (matched) begin
            wait_rply(1'b1, S + 4, ok);
            chk({tag, "_rply"}, ok, 1'b1);
            repeat (4) @(negedge clk);
            chk({tag, "_pulses"}, wr_pulses - w0, 1);
            chk({tag, "_single"}, wr_doubles - dd0, 0);
            chk({tag, "_wfields"}, {wr_data_seen, wr_byte_seen, wr_addr_seen}, {d, bw, a});
            chk({tag, "_nooe"}, oe_cyc - o0, 0);
            bus.qDOUT = 1'b0;
            wait_rply(1'b0, S + 1, ok);
            chk({tag, "_drop"}, ok, 1'b1);
            mask = !bw ? 16'hFFFF : (a[0] ? 16'hFF00 : 16'h00FF);
            mdl[a[1]] = (mdl[a[1]] & ~mask) | (d & mask);
        end else begin
            repeat (12) @(negedge clk);
            chk({tag, "_nowrite"}, wr_pulses - w0, 0);
            chk({tag, "_norply"}, rply_cyc - r0, 0);
            bus.qDOUT = 1'b0;
            repeat (S + 2) @(negedge clk);
        end
        bus.qWTBT = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0, op, sel, idx;
        logic [12:0] a;
        logic        b7, matched;
        logic [15:0] d;
        logic        ok;

        bus.qDAL_in = 16'h0000; bus.qBS7 = 1'b0; bus.qSYNC = 1'b0;
        bus.qDIN = 1'b0; bus.qDOUT = 1'b0; bus.qWTBT = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_outputs", {bus.qDAL_out, bus.qDAL_oe, bus.qRPLY, bus.iADDR, bus.iBS7,
                              bus.iWRITE, bus.iWDATA, bus.iBYTE}, 64'd0);
        reset_n = 1'b1;
        repeat (S + 4) @(negedge clk);

        // DATI at BASE
        sync_on(BASE, 1'b1);
        do_read("dati", 1'b1, mdl[0]);
        sync_off();

        // DATO then DATI at BASE+2
        sync_on(BASE + 13'd2, 1'b1);
        do_write("dato", 1'b1, 16'o052525, 1'b0, BASE + 13'd2);
        sync_off();
        sync_on(BASE + 13'd2, 1'b1);
        do_read("dati_after_dato", 1'b1, mdl[1]);
        chk("dato_value", mdl[1], 16'o052525);
        sync_off();

        // Unmatched address: DIN then DOUT in one cycle
        sync_on(13'o17700, 1'b1);
        do_read("unm_rd", 1'b0, 16'h0000);
        do_write("unm_wr", 1'b0, 16'h1234, 1'b0, 13'o17700);
        sync_off();

        // DATIO with byte write
        sync_on(BASE, 1'b1);
        do_read("datio_rd", 1'b1, mdl[0]);
        chk("datio_addr_rd", bus.iADDR, BASE);
        do_write("datio_wr", 1'b1, 16'o000777, 1'b1, BASE);
        chk("datio_addr_wr", bus.iADDR, BASE);
        sync_off();
        sync_on(BASE, 1'b1);
        do_read("datio_back", 1'b1, 16'hA7FF);
        sync_off();

        // SYNC negated during RD_RPLY with DIN held
        sync_on(BASE, 1'b1);
        @(negedge clk);
        bus.qDIN = 1'b1;
        wait_rply(1'b1, S + DS + 2, ok);
        chk("abort_rply_up", ok, 1'b1);
        bus.qSYNC = 1'b0;
        repeat (S + 1) @(negedge clk);
        chk("abort_drop", {bus.qRPLY, bus.qDAL_oe, bus.iBS7}, 3'b000);
        chk("abort_addr_hold", bus.iADDR, BASE);
        bus.qDIN = 1'b0;
        repeat (S + 2) @(negedge clk);

        // Reset pulse during RD_RPLY with SYNC held
        sync_on(BASE, 1'b1);
        @(negedge clk);
        bus.qDIN = 1'b1;
        wait_rply(1'b1, S + DS + 2, ok);
        chk("rst_rply_up", ok, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_mid_outputs", {bus.qDAL_out, bus.qDAL_oe, bus.qRPLY, bus.iADDR, bus.iBS7,
                                bus.iWRITE, bus.iWDATA, bus.iBYTE}, 64'd0);
        r0 = rply_cyc;
        repeat (15) @(negedge clk);
        chk("rst_no_rejoin", rply_cyc - r0, 0);
        bus.qDIN  = 1'b0;
        bus.qSYNC = 1'b0;
        repeat (S + 4) @(negedge clk);
        sync_on(BASE + 13'd2, 1'b1);
        do_read("rst_next", 1'b1, mdl[1]);
        sync_off();

        // Random cycles
        for (int t = 0; t < 16; t++) begin
            op  = $urandom_range(0, 2);
            sel = $urandom_range(0, 3);
            d   = 16'($urandom);
            case (sel)
                0, 1:    begin a = BASE + 13'(2 * sel); b7 = 1'b1; matched = 1'b1; end
                2:       begin a = BASE; b7 = 1'b0; matched = 1'b0; end
                default: begin a = 13'($urandom_range(0, 8183)); b7 = 1'b1; matched = 1'b0; end
            endcase
            a[0] = (op == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            idx  = int'(a[1]);
            sync_on(a, b7);
            if (op == 0) do_read("rnd_rd", matched, mdl[idx]);
            else         do_write("rnd_wr", matched, d, (op == 2), a);
            sync_off();
        end

        sync_on(BASE, 1'b1);
        do_read("final_r0", 1'b1, mdl[0]);
        sync_off();
        sync_on(BASE + 13'd2, 1'b1);
        do_read("final_r1", 1'b1, mdl[1]);
        sync_off();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
